// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the multi-cycle LEGv8 control unit: states, opcode classes,
// opcode match patterns, ALUOp classes and exception codes.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE   = 3'd0,
    CL_IMM     = 3'd1,
    CL_LDUR    = 3'd2,
    CL_STUR    = 3'd3,
    CL_CBZ     = 3'd4,
    CL_CBNZ    = 3'd5,
    CL_B       = 3'd6,
    CL_ILLEGAL = 3'd7
  } op_class_t;

  // Opcode patterns for casez matching; '?' bits belong to the immediate/offset field.
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100???;
  localparam logic [10:0] OPC_CBNZ = 11'b10110101???;
  localparam logic [10:0] OPC_B    = 11'b000101?????;
  localparam logic [10:0] OPC_ADDI = 11'b1001000100?;
  localparam logic [10:0] OPC_SUBI = 11'b1101000100?;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] EXC_NONE        = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL     = 2'b01;
  localparam logic [1:0] EXC_MEM_TIMEOUT = 2'b10;

endpackage

// File: rtl/legv8_op_classifier.sv
// Combinational opcode classifier; the opcode occupies the top 11 bits of op.
module legv8_op_classifier
  import legv8_ctrl_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [OP_W-1:0] op,
  output op_class_t       cls
);

  logic [10:0] op11;
  assign op11 = op[OP_W-1 -: 11];

  always_comb begin
    cls = CL_ILLEGAL;
    casez (op11)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: cls = CL_RTYPE;
      OPC_ADDI, OPC_SUBI:                 cls = CL_IMM;
      OPC_LDUR:                           cls = CL_LDUR;
      OPC_STUR:                           cls = CL_STUR;
      OPC_CBZ:                            cls = CL_CBZ;
      OPC_CBNZ:                           cls = CL_CBNZ;
      OPC_B:                              cls = CL_B;
      default:                            cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Multi-cycle LEGv8 main control: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory-ack timeout and a terminal exception state.
module multicycle_maindec
  import legv8_ctrl_pkg::*;
#(
  parameter int OP_W        = 11,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic               Zero,
  input  logic               mem_ack,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               IRWrite,
  output logic               Reg2Loc,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Exc,
  output logic [1:0]         ExcCode,
  output logic [2:0]         State
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state;
  op_class_t       cls;
  op_class_t       cls_dec;
  logic [CNT_W-1:0] cnt;
  logic            exc;
  logic [1:0]      exc_code;
  logic [1:0]      alu_op;
  logic            take;

  legv8_op_classifier #(.OP_W(OP_W)) u_cls (
    .op  (Op),
    .cls (cls_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      cls      <= CL_ILLEGAL;
      cnt      <= '0;
      exc      <= 1'b0;
      exc_code <= EXC_NONE;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          cls <= cls_dec;
          if (cls_dec == CL_ILLEGAL) begin
            state    <= S_EXC;
            exc      <= 1'b1;
            exc_code <= EXC_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= '0;
          case (cls)
            CL_LDUR, CL_STUR: state <= S_MEM;
            CL_RTYPE, CL_IMM: state <= S_WB;
            default:          state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            cnt   <= '0;
            state <= (cls == CL_LDUR) ? S_WB : S_FETCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // This is the MEM_TIMEOUT-th cycle without an ack.
            if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
              state    <= S_EXC;
              exc      <= 1'b1;
              exc_code <= EXC_MEM_TIMEOUT;
            end
          end
        end
        S_WB:    state <= S_FETCH;
        S_EXC:   state <= S_EXC;
        default: state <= S_EXC;
      endcase
    end
  end

  // Decode straight from the registered state so reset kills MemRead/MemWrite at once.
  assign take = Zero ^ (cls == CL_CBNZ);

  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    alu_op   = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_DECODE: Reg2Loc = (cls_dec == CL_STUR) || (cls_dec == CL_CBZ) || (cls_dec == CL_CBNZ);
      S_EXEC: begin
        case (cls)
          CL_RTYPE: alu_op = ALUOP_FUNCT;
          CL_IMM: begin
            ALUSrc = 1'b1;
            alu_op = ALUOP_IMM;
          end
          CL_LDUR, CL_STUR: ALUSrc = 1'b1;
          CL_CBZ, CL_CBNZ: begin
            alu_op  = ALUOP_PASSB;
            Branch  = 1'b1;
            PCSrc   = take;
            PCWrite = take;
          end
          CL_B: begin
            Branch  = 1'b1;
            PCSrc   = 1'b1;
            PCWrite = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        MemRead  = (cls == CL_LDUR);
        MemWrite = (cls == CL_STUR);
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (cls == CL_LDUR);
      end
      default: ;
    endcase
  end

  assign ALUOp   = ALUOP_W'(alu_op);
  assign Exc     = exc;
  assign ExcCode = exc_code;
  assign State   = state;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Cycle-by-cycle check of the multi-cycle LEGv8 controller against hand-derived
// state/control vectors, plus timeout, illegal-opcode and async-reset sequences.
module tb_multicycle_maindec;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] op = '0;
  logic        zero = 1'b0;
  logic        ack = 1'b0;
  logic        pc_write, pc_src, ir_write, reg2loc, alu_src, memtoreg;
  logic        reg_write, mem_read, mem_write, branch, exc;
  logic [1:0]  alu_op, exc_code;
  logic [2:0]  state;

  multicycle_maindec #(.OP_W(11), .ALUOP_W(2), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Op(op), .Zero(zero), .mem_ack(ack),
    .PCWrite(pc_write), .PCSrc(pc_src), .IRWrite(ir_write), .Reg2Loc(reg2loc),
    .ALUSrc(alu_src), .MemtoReg(memtoreg), .RegWrite(reg_write), .MemRead(mem_read),
    .MemWrite(mem_write), .Branch(branch), .ALUOp(alu_op), .Exc(exc),
    .ExcCode(exc_code), .State(state)
  );

  always #5 clk = ~clk;

  // Control word: PCWrite PCSrc IRWrite Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0]
  localparam logic [11:0] C_0   = 12'h000;
  localparam logic [11:0] C_F   = 12'hA00;
  localparam logic [11:0] C_D1  = 12'h100;
  localparam logic [11:0] C_ER  = 12'h002;
  localparam logic [11:0] C_EI  = 12'h083;
  localparam logic [11:0] C_EM  = 12'h080;
  localparam logic [11:0] C_EBT = 12'hC05;
  localparam logic [11:0] C_EBN = 12'h005;
  localparam logic [11:0] C_EB  = 12'hC04;
  localparam logic [11:0] C_MR  = 12'h010;
  localparam logic [11:0] C_MW  = 12'h008;
  localparam logic [11:0] C_WR  = 12'h020;
  localparam logic [11:0] C_WL  = 12'h060;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SX = 3'd5;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001001;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_CBNZ = 11'b10110101011;
  localparam logic [10:0] OP_B    = 11'b00010110011;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic        exc;
    logic [1:0]  code;
  } exp_t;

  typedef struct {
    logic [10:0] op;
    logic        zero;
    logic        ack;
    exp_t        exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  string tag;

  function automatic void add(input logic [10:0] o, input logic z, input logic a,
                              input logic [2:0] s, input logic [11:0] c);
    vec_t v;
    v.op = o; v.zero = z; v.ack = a;
    v.exp = '{st: s, ctl: c, exc: 1'b0, code: 2'b00};
    vecs.push_back(v);
  endfunction

  task automatic check_out();
    exp_t e, a;
    a = '{st: state,
          ctl: {pc_write, pc_src, ir_write, reg2loc, alu_src, memtoreg, reg_write,
                mem_read, mem_write, branch, alu_op},
          exc: exc, code: exc_code};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued", tag);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d ctl=%03h exc=%b code=%b, want st=%0d ctl=%03h exc=%b code=%b",
                 tag, a.st, a.ctl, a.exc, a.code, e.st, e.ctl, e.exc, e.code);
      end
    end
  endtask

  // Drive one cycle's inputs at the negedge, queue the expectation and sample 1ns later.
  task automatic apply(input logic [10:0] o, input logic z, input logic a, input exp_t e);
    op = o; zero = z; ack = a;
    sb.push_back(e);
    #1 check_out();
  endtask

  task automatic row(input logic [10:0] o, input logic z, input logic a, input exp_t e);
    apply(o, z, a, e);
    @(negedge clk);
  endtask

  // Async reset pulse; the outputs must show FETCH with no exception before any clock edge.
  task automatic pulse_reset();
    reset = 1'b1;
    sb.push_back('{st: SF, ctl: C_F, exc: 1'b0, code: 2'b00});
    #1 check_out();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    tag = "reset";
    pulse_reset();

    // Instruction sequences; mem_ack is also raised outside MEM, where it must be ignored.
    add(OP_ADD, 0, 1, SF, C_F);  add(OP_ADD, 0, 0, SD, C_0);   add(OP_ADD, 0, 1, SE, C_ER);  add(OP_ADD, 0, 0, SW, C_WR);
    add(OP_SUB, 1, 0, SF, C_F);  add(OP_SUB, 1, 0, SD, C_0);   add(OP_SUB, 1, 0, SE, C_ER);  add(OP_SUB, 1, 1, SW, C_WR);
    add(OP_AND, 0, 0, SF, C_F);  add(OP_AND, 0, 0, SD, C_0);   add(OP_AND, 0, 0, SE, C_ER);  add(OP_AND, 0, 0, SW, C_WR);
    add(OP_ORR, 0, 0, SF, C_F);  add(OP_ORR, 0, 0, SD, C_0);   add(OP_ORR, 0, 0, SE, C_ER);  add(OP_ORR, 0, 0, SW, C_WR);
    add(OP_ADDI, 0, 0, SF, C_F); add(OP_ADDI, 0, 0, SD, C_0);  add(OP_ADDI, 0, 0, SE, C_EI); add(OP_ADDI, 0, 0, SW, C_WR);
    add(OP_SUBI, 0, 0, SF, C_F); add(OP_SUBI, 0, 0, SD, C_0);  add(OP_SUBI, 0, 0, SE, C_EI); add(OP_SUBI, 0, 0, SW, C_WR);
    // LDUR: ack in the third MEM cycle, 7 cycles FETCH to FETCH.
    add(OP_LDUR, 0, 0, SF, C_F); add(OP_LDUR, 0, 0, SD, C_0);  add(OP_LDUR, 0, 0, SE, C_EM);
    add(OP_LDUR, 0, 0, SM, C_MR); add(OP_LDUR, 0, 0, SM, C_MR); add(OP_LDUR, 0, 1, SM, C_MR); add(OP_LDUR, 0, 0, SW, C_WL);
    // STUR: ack in the very first MEM cycle.
    add(OP_STUR, 0, 0, SF, C_F); add(OP_STUR, 0, 0, SD, C_D1); add(OP_STUR, 0, 0, SE, C_EM); add(OP_STUR, 0, 1, SM, C_MW);
    add(OP_CBZ, 1, 0, SF, C_F);  add(OP_CBZ, 1, 0, SD, C_D1);  add(OP_CBZ, 1, 0, SE, C_EBT);
    add(OP_CBNZ, 1, 0, SF, C_F); add(OP_CBNZ, 1, 0, SD, C_D1); add(OP_CBNZ, 1, 0, SE, C_EBN);
    add(OP_CBZ, 0, 0, SF, C_F);  add(OP_CBZ, 0, 0, SD, C_D1);  add(OP_CBZ, 0, 0, SE, C_EBN);
    add(OP_CBNZ, 0, 0, SF, C_F); add(OP_CBNZ, 0, 0, SD, C_D1); add(OP_CBNZ, 0, 0, SE, C_EBT);
    add(OP_B, 1, 0, SF, C_F);    add(OP_B, 1, 0, SD, C_0);     add(OP_B, 1, 0, SE, C_EB);
    add(OP_ADD, 0, 0, SF, C_F);

    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      row(vecs[i].op, vecs[i].zero, vecs[i].ack, vecs[i].exp);
    end
    // Last vector left the FSM in DECODE of an ADD; restart cleanly.
    tag = "reset2";
    pulse_reset();

    // STUR that never gets an ack: 15 MEM cycles, then EXC with MemWrite already low.
    tag = "to_f"; row(OP_STUR, 0, 0, '{SF, C_F, 1'b0, 2'b00});
    tag = "to_d"; row(OP_STUR, 0, 0, '{SD, C_D1, 1'b0, 2'b00});
    tag = "to_e"; row(OP_STUR, 0, 0, '{SE, C_EM, 1'b0, 2'b00});
    for (int i = 0; i < 15; i++) begin
      tag = $sformatf("to_mem%0d", i);
      row(OP_STUR, 0, 0, '{SM, C_MW, 1'b0, 2'b00});
    end
    tag = "to_exc";  row(OP_STUR, 0, 1, '{SX, C_0, 1'b1, 2'b10});
    tag = "to_held"; row(OP_ADD, 1, 1, '{SX, C_0, 1'b1, 2'b10});
    tag = "to_reset"; pulse_reset();

    // Illegal opcode, then an async reset pulse in the middle of an EXC cycle.
    tag = "ill_f";   row(OP_ILL, 0, 0, '{SF, C_F, 1'b0, 2'b00});
    tag = "ill_d";   row(OP_ILL, 0, 0, '{SD, C_0, 1'b0, 2'b00});
    tag = "ill_exc"; row(OP_ADD, 0, 0, '{SX, C_0, 1'b1, 2'b01});
    tag = "ill_hold"; apply(OP_LDUR, 0, 1, '{SX, C_0, 1'b1, 2'b01});
    #1 tag = "ill_reset"; pulse_reset();

    // LDUR aborted by reset mid-MEM: MemRead must fall before the next clock edge.
    tag = "ab_f"; row(OP_LDUR, 0, 0, '{SF, C_F, 1'b0, 2'b00});
    tag = "ab_d"; row(OP_LDUR, 0, 0, '{SD, C_0, 1'b0, 2'b00});
    tag = "ab_e"; row(OP_LDUR, 0, 0, '{SE, C_EM, 1'b0, 2'b00});
    tag = "ab_m"; apply(OP_LDUR, 0, 0, '{SM, C_MR, 1'b0, 2'b00});
    #1 tag = "ab_reset"; pulse_reset();

    // Clean ADD after the abort.
    tag = "post_f"; row(OP_ADD, 0, 0, '{SF, C_F, 1'b0, 2'b00});
    tag = "post_d"; row(OP_ADD, 0, 0, '{SD, C_0, 1'b0, 2'b00});
    tag = "post_e"; row(OP_ADD, 0, 0, '{SE, C_ER, 1'b0, 2'b00});
    tag = "post_w"; row(OP_ADD, 0, 0, '{SW, C_WR, 1'b0, 2'b00});
    tag = "post_f2"; row(OP_ADD, 0, 0, '{SF, C_F, 1'b0, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
